// File: rtl/dcache_store_unit.sv
// In-order store buffer between MEM stage and the dcache write port: lane replication,
// byte-enable generation, DEPTH-entry FIFO and an IDLE/WRITE drain FSM. Optional: STORE_MISALIGN_TRAP_EN.
module dcache_store_unit #(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [2:0]    st_funct3,
    input  logic [31:0]   st_addr,
    input  logic [31:0]   st_data,
    output logic          mem_write,
    output logic [31:0]   mem_address,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_byte_enable,
    input  logic          mem_resp,
    output logic          sb_empty,
    output logic [CW-1:0] sb_count,
    output logic          misalign_err
);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [29:0]   buf_addr_q  [DEPTH];
    logic [31:0]   buf_wdata_q [DEPTH];
    logic [3:0]    buf_be_q    [DEPTH];

    logic [1:0]    ofs;
    logic [31:0]   ent_wdata;
    logic [3:0]    ent_be;
    logic          ent_ok;
    logic          accept, push, pop;

    assign ofs = st_addr[1:0];

    // Lane replication: the dcache takes the whole word and only commits enabled lanes.
    always_comb begin
        ent_wdata = st_data;
        ent_be    = 4'b0000;
        ent_ok    = 1'b0;
        case (st_funct3)
            3'b000: begin
                ent_wdata = {4{st_data[7:0]}};
                ent_be    = 4'b0001 << ofs;
                ent_ok    = 1'b1;
            end
            3'b001: begin
                ent_wdata = {2{st_data[15:0]}};
                ent_be    = 4'b0011 << {ofs[1], 1'b0};
                ent_ok    = 1'b1;
            end
            3'b010: begin
                ent_wdata = st_data;
                ent_be    = 4'b1111;
                ent_ok    = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef STORE_MISALIGN_TRAP_EN
    logic misaligned;
    logic misalign_q, misalign_d;

    assign misaligned = ((st_funct3 == 3'b001) && ofs[0]) ||
                        ((st_funct3 == 3'b010) && (ofs != 2'b00));
    assign push       = accept && ent_ok && !misaligned;
    assign misalign_d = accept && misaligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_q <= 1'b0;
        else        misalign_q <= misalign_d;
    end
    assign misalign_err = misalign_q;
`else
    assign push         = accept && ent_ok;
    assign misalign_err = 1'b0;
`endif

    // Unsupported funct3 still completes the handshake so the pipeline never stalls on it.
    assign accept = st_valid && st_ready;
    assign pop    = (state_q == WRITE) && mem_resp;

    always_comb begin
        count_d  = count_q + CW'(push) - CW'(pop);
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        state_d  = state_q;
        case (state_q)
            IDLE:    if (count_q != '0) state_d = WRITE;
            WRITE:   if (pop && (count_d == '0)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload storage needs no reset; outputs are gated by the FSM state.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr_q[wr_ptr_q]  <= st_addr[31:2];
            buf_wdata_q[wr_ptr_q] <= ent_wdata;
            buf_be_q[wr_ptr_q]    <= ent_be;
        end
    end

    assign mem_write       = (state_q == WRITE);
    assign mem_address     = mem_write ? {buf_addr_q[rd_ptr_q], 2'b00} : 32'h0;
    assign mem_wdata       = mem_write ? buf_wdata_q[rd_ptr_q] : 32'h0;
    assign mem_byte_enable = mem_write ? buf_be_q[rd_ptr_q] : 4'h0;

    assign st_ready = (count_q != CW'(DEPTH));
    assign sb_empty = (count_q == '0);
    assign sb_count = count_q;

endmodule
